vga_timing_gen: RTL and testbench

- Raster timing generator for the 640x480@60 VGA path, running on the 25 MHz pixel clock.
- Produces the DrawX/DrawY/blank position stream consumed directly by the sprite/ROM pixel stages.
- Produces horizontal/vertical sync, plus copies of sync delayed one cycle to match the one-cycle registered colour output of those stages.
- Also emits frame and line start strobes for game-logic and double-buffer swap timing.

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for 640x480@60 on the 25 MHz pixel clock.
// Emits DrawX/DrawY/blank, hs/vs, one-cycle-delayed pixel_hs/pixel_vs,
// and frame/line start strobes. All outputs come straight from registers.
// Optional feature: define VGA_FRAME_COUNTER_EN to enable the 16-bit frame_count;
// without it frame_count is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        pixel_hs,
    output logic        pixel_vs,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       hc_wrap;
    logic       frame_start_next;

    assign DrawX = hc;
    assign DrawY = vc;

    // Next raster position; every registered output is decoded from it so
    // that all outputs describe the same position on the same edge.
    always_comb begin
        hc_wrap = (hc == H_MAX);
        hc_next = hc_wrap ? 10'd0 : hc + 10'd1;
        vc_next = vc;
        if (hc_wrap) begin
            vc_next = (vc == V_MAX) ? 10'd0 : vc + 10'd1;
        end
        frame_start_next = (hc_next == 10'd0) && (vc_next == 10'd0);
    end

    // Position counters, decoded video/sync/strobe outputs and sync delay stage.
    // Reset parks the raster on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= H_MAX;
            vc          <= V_MAX;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            pixel_hs    <= ~SYNC_POL;
            pixel_vs    <= ~SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
            hs          <= ((hc_next >= HS_FIRST) && (hc_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
            vs          <= ((vc_next >= VS_FIRST) && (vc_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
            pixel_hs    <= hs;
            pixel_vs    <= vs;
            frame_start <= frame_start_next;
            line_start  <= (hc_next == 10'd0) && (vc_next < V_VIS);
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;

    // Counts frames; bumps on the same edge that raises frame_start, wraps naturally.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 16'd0;
        end else if (frame_start_next) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small-raster
// instance (active-high sync) checked every cycle against an arithmetic model
// of raster position versus cycles since reset release.
module tb_vga_timing_gen;

    // Small raster: 32 x 13 = 416 cycles per frame.
    localparam int SHV = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVV = 6,  SVF = 2, SVS = 2, SVB = 3;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        phs;
        logic        pvs;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int   t;
        int   x;
        int   y;
        logic blank;
        logic hs;
        logic vs;
        logic phs;
        logic fs;
        logic ls;
    } vec_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_blank, d_hs, d_vs, d_phs, d_pvs, d_fs, d_ls;
    logic        s_blank, s_hs, s_vs, s_phs, s_pvs, s_fs, s_ls;
    logic [15:0] d_fc, s_fc;

    int   t = 0;
    int   checks = 0;
    int   passed = 0;
    logic run_chk = 1'b0;
    logic fc_skip = 1'b0;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .pixel_hs(d_phs), .pixel_vs(d_pvs), .frame_start(d_fs),
        .line_start(d_ls), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b1)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .pixel_hs(s_phs), .pixel_vs(s_pvs), .frame_start(s_fs),
        .line_start(s_ls), .frame_count(s_fc)
    );

    always #5 vga_clk = ~vga_clk;

    // Cycles since reset release: t == k after the k-th rising edge.
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) t <= 0;
        else          t <= t + 1;
    end

    function automatic logic sync_lvl(int p, int first, int width, logic pol);
        return (p >= first && p <= first + width - 1) ? pol : ~pol;
    endfunction

    // Expected outputs from position = (t-1) mod line / frame arithmetic.
    function automatic obs_t model(int tc, int hv, int hf, int hsn, int hb,
                                   int vv, int vf, int vsn, int vb, logic pol);
        obs_t e;
        int ht, vt, n, x, y, px, py;
        ht = hv + hf + hsn + hb;
        vt = vv + vf + vsn + vb;
        if (tc == 0) begin
            e.x = 10'(ht - 1); e.y = 10'(vt - 1);
            e.blank = 1'b0; e.hs = ~pol; e.vs = ~pol; e.phs = ~pol; e.pvs = ~pol;
            e.fs = 1'b0; e.ls = 1'b0; e.fc = 16'd0;
            return e;
        end
        n = tc - 1;
        x = n % ht;
        y = (n / ht) % vt;
        e.x = 10'(x);
        e.y = 10'(y);
        e.blank = (x < hv) && (y < vv);
        e.hs = sync_lvl(x, hv + hf, hsn, pol);
        e.vs = sync_lvl(y, vv + vf, vsn, pol);
        if (tc == 1) begin
            e.phs = ~pol; e.pvs = ~pol;
        end else begin
            px = (n - 1) % ht;
            py = ((n - 1) / ht) % vt;
            e.phs = sync_lvl(px, hv + hf, hsn, pol);
            e.pvs = sync_lvl(py, vv + vf, vsn, pol);
        end
        e.fs = (x == 0) && (y == 0);
        e.ls = (x == 0) && (y < vv);
`ifdef VGA_FRAME_COUNTER_EN
        e.fc = 16'((n / (ht * vt)) + 1);
`else
        e.fc = 16'd0;
`endif
        return e;
    endfunction

    function automatic obs_t model_d(int tc);
        return model(tc, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic obs_t model_s(int tc);
        return model(tc, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1);
    endfunction

    function automatic obs_t obs_d();
        obs_t o;
        o.x = d_x; o.y = d_y; o.blank = d_blank; o.hs = d_hs; o.vs = d_vs;
        o.phs = d_phs; o.pvs = d_pvs; o.fs = d_fs; o.ls = d_ls; o.fc = d_fc;
        return o;
    endfunction

    function automatic obs_t obs_s();
        obs_t o;
        o.x = s_x; o.y = s_y; o.blank = s_blank; o.hs = s_hs; o.vs = s_vs;
        o.phs = s_phs; o.pvs = s_pvs; o.fs = s_fs; o.ls = s_ls; o.fc = s_fc;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_all(input string tag, input obs_t a, input obs_t e, input logic skip_fc);
        chk({tag, ".DrawX"}, 32'(a.x), 32'(e.x));
        chk({tag, ".DrawY"}, 32'(a.y), 32'(e.y));
        chk({tag, ".blank"}, 32'(a.blank), 32'(e.blank));
        chk({tag, ".hs"}, 32'(a.hs), 32'(e.hs));
        chk({tag, ".vs"}, 32'(a.vs), 32'(e.vs));
        chk({tag, ".pixel_hs"}, 32'(a.phs), 32'(e.phs));
        chk({tag, ".pixel_vs"}, 32'(a.pvs), 32'(e.pvs));
        chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
        chk({tag, ".line_start"}, 32'(a.ls), 32'(e.ls));
        if (!skip_fc) chk({tag, ".frame_count"}, 32'(a.fc), 32'(e.fc));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge vga_clk) begin
        if (run_chk) begin
            chk_all("d", obs_d(), model_d(t), 1'b0);
            chk_all("s", obs_s(), model_s(t), fc_skip);
        end
    end

    // Asynchronous reset: assert a few ns after an edge and check before the next one.
    task automatic async_reset(input int offset);
        @(posedge vga_clk);
        #(offset);
        reset_n = 1'b0;
        #1;
        chk_all("d_async", obs_d(), model_d(0), 1'b0);
        chk_all("s_async", obs_s(), model_s(0), 1'b0);
        fc_skip = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t vecs[13];
    int   guard;
    int   hs_low, blank_cnt, vs_cnt, ls_cnt, fs_cnt;
    logic [15:0] fc_first;

    initial begin
        //           t     x    y  blank hs vs phs fs ls
        vecs[0]  = '{1,    0,   0, 1, 1, 1, 1, 1, 1};
        vecs[1]  = '{2,    1,   0, 1, 1, 1, 1, 0, 0};
        vecs[2]  = '{640,  639, 0, 1, 1, 1, 1, 0, 0};
        vecs[3]  = '{641,  640, 0, 0, 1, 1, 1, 0, 0};
        vecs[4]  = '{656,  655, 0, 0, 1, 1, 1, 0, 0};
        vecs[5]  = '{657,  656, 0, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{658,  657, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{752,  751, 0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{753,  752, 0, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{754,  753, 0, 0, 1, 1, 1, 0, 0};
        vecs[10] = '{800,  799, 0, 0, 1, 1, 1, 0, 0};
        vecs[11] = '{801,  0,   1, 1, 1, 1, 1, 0, 1};
        vecs[12] = '{1601, 0,   2, 1, 1, 1, 1, 0, 1};

        // Reset held for 5 cycles.
        repeat (5) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("reset.DrawX", 32'(d_x), 32'd799);
        chk("reset.DrawY", 32'(d_y), 32'd524);
        chk("reset.blank", 32'(d_blank), 32'd0);
        chk("reset.hs", 32'(d_hs), 32'd1);
        chk("reset.vs", 32'(d_vs), 32'd1);
        chk("reset.frame_count", 32'(d_fc), 32'd0);
        run_chk = 1'b1;
        release_reset();

        // Table of landmark positions on the default raster.
        for (int i = 0; i < 13; i++) begin
            guard = 0;
            while (t < vecs[i].t && guard < 5000) begin
                @(negedge vga_clk);
                guard++;
            end
            chk("table.reached", 32'(t), 32'(vecs[i].t));
            chk("table.DrawX", 32'(d_x), 32'(vecs[i].x));
            chk("table.DrawY", 32'(d_y), 32'(vecs[i].y));
            chk("table.blank", 32'(d_blank), 32'(vecs[i].blank));
            chk("table.hs", 32'(d_hs), 32'(vecs[i].hs));
            chk("table.vs", 32'(d_vs), 32'(vecs[i].vs));
            chk("table.pixel_hs", 32'(d_phs), 32'(vecs[i].phs));
            chk("table.frame_start", 32'(d_fs), 32'(vecs[i].fs));
            chk("table.line_start", 32'(d_ls), 32'(vecs[i].ls));
        end

        // One full line: hs low for exactly 96 cycles, DrawY steps once.
        hs_low = 0;
        repeat (800) begin
            @(negedge vga_clk);
            if (d_hs == 1'b0) hs_low++;
        end
        chk("line.hs_low_cycles", 32'(hs_low), 32'd96);
        chk("line.DrawY_after_800", 32'(d_y), 32'd3);

        // Async reset mid-frame, then one small-raster frame of aggregate counts.
        async_reset(2);
        release_reset();
        blank_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0; fc_first = 16'hdead;
        repeat (416) begin
            @(negedge vga_clk);
            if (s_blank) blank_cnt++;
            if (s_vs) vs_cnt++;
            if (s_ls) ls_cnt++;
            if (s_fs) begin
                fs_cnt++;
                fc_first = s_fc;
            end
        end
        chk("frame.blank_cycles", 32'(blank_cnt), 32'(SHV * SVV));
        chk("frame.vs_cycles", 32'(vs_cnt), 32'(SVS * 32));
        chk("frame.line_starts", 32'(ls_cnt), 32'(SVV));
        chk("frame.frame_starts", 32'(fs_cnt), 32'd1);
        @(negedge vga_clk);
        chk("frame2.frame_start", 32'(s_fs), 32'd1);
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame1.frame_count", 32'(fc_first), 32'd1);
        chk("frame2.frame_count", 32'(s_fc), 32'd2);
`else
        chk("frame1.frame_count", 32'(fc_first), 32'd0);
        chk("frame2.frame_count", 32'(s_fc), 32'd0);
`endif
        repeat (416) @(negedge vga_clk);
        chk("frame3.frame_start", 32'(s_fs), 32'd1);
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame3.frame_count", 32'(s_fc), 32'd3);

        // Counter wrap: force to 0xFFFF mid-frame, next frame start gives 0.
        repeat (100) @(negedge vga_clk);
        fc_skip = 1'b1;
        force dut_s.frame_cnt = 16'hffff;
        @(negedge vga_clk);
        release dut_s.frame_cnt;
        @(negedge vga_clk);
        chk("wrap.held", 32'(s_fc), 32'hffff);
        guard = 0;
        while (!s_fs && guard < 1000) begin
            @(negedge vga_clk);
            guard++;
        end
        chk("wrap.frame_start_seen", 32'(s_fs), 32'd1);
        chk("wrap.frame_count", 32'(s_fc), 32'd0);
`else
        chk("frame3.frame_count", 32'(s_fc), 32'd0);
`endif

        // Randomised reset assertion points and hold lengths.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 3000)) @(posedge vga_clk);
            async_reset(int'($urandom_range(1, 4)));
            repeat ($urandom_range(1, 3)) @(negedge vga_clk);
            release_reset();
        end
        repeat ($urandom_range(50, 900)) @(negedge vga_clk);

        run_chk = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
